my_mux_4_way_rr: RTL and testbench

Four-channel round-robin merge: collects data from four valid/ready source channels onto one registered output channel and tags each word with the 2-bit index of the channel it came from. It is the gathering end of the 4-way demux path. A word steered out on channel `sel` by the demux re-enters here, and `out_sel` carries that index back downstream. Arbitration is fair round-robin, and no source can starve another.

---
 rtl/my_mux_4_way_rr.sv | 68 ++++++
 tb/tb_my_mux_4_way_rr.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/my_mux_4_way_rr.sv
// Four-channel round-robin merge onto one registered valid/ready output.
// out_sel tags each word with the index of the channel it came from.
module my_mux_4_way_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       ptr;
  logic [1:0]       gidx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] words [4];

  for (genvar i = 0; i < 4; i++) begin : g_words
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = !out_valid || out_ready;

  // Search starts at ptr and wraps; first valid channel wins.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    gidx  = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load && found) begin
      in_ready[gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= words[gidx];
        out_sel   <= gidx;
        ptr       <= gidx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_my_mux_4_way_rr.sv
// Directed plus randomized bench for my_mux_4_way_rr.
// A queue-free arithmetic model tracks the output register and priority.
module tb_my_mux_4_way_rr;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  bit       m_valid = 0;
  int       m_data  = 0;
  int       m_sel   = 0;
  int       m_ptr   = 0;
  logic [3:0] acc;

  always #5 clk = ~clk;

  my_mux_4_way_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int word(input int i);
    return int'(in_data[i*W +: W]);
  endfunction

  task automatic set_word(input int i, input int d);
    in_data[i*W +: W] = d[W-1:0];
  endtask

  // One clock: check grant, advance the model at the edge, check outputs.
  task automatic step();
    int w;
    bit ld;
    logic [3:0] er;
    #1;
    w  = winner();
    ld = !m_valid || out_ready;
    er = 4'b0000;
    if (rst_n && ld && w >= 0) er[w] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    acc = er;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = word(w);
        m_sel   = w;
        m_ptr   = (w + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    acc       = '0;

    // Reset with every source asking
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_sel", 32'(out_sel), 32'd0);

    // Single channel
    in_valid = 4'b0100;
    set_word(2, 'hA5);
    #1;
    chk("single_ready", 32'(in_ready), 32'h4);
    step();
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_sel", 32'(out_sel), 32'd2);

    // Fair rotation from ptr 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_word(i, 'h10 + i);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rot_sel", 32'(out_sel), 32'(k % 4));
      chk("rot_data", 32'(out_data), 32'h10 + 32'(out_sel));
    end

    // Stall holding channel 1's word with ptr at 2
    in_valid = 4'b0010;
    set_word(1, 'h11);
    step();
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    set_word(0, 'h20);
    set_word(3, 'h23);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'h11);
      chk("stall_sel", 32'(out_sel), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("unstall_sel3", 32'(out_sel), 32'd3);
    in_valid = 4'b0001;
    step();
    chk("unstall_sel0", 32'(out_sel), 32'd0);

    // Drain with no sources
    in_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'h20);
    chk("drain_sel", 32'(out_sel), 32'd0);

    // Reset mid-stream with ptr at 3
    in_valid = 4'b0100;
    step();
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    step();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_sel", 32'(out_sel), 32'd0);

    // Random traffic; sources hold until granted
    in_valid = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 2) != 0);
          set_word(i, int'($urandom_range(0, 255)));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
